argmax_unit: RTL and testbench

ARGMAX_UNIT -- requirements
Module: argmax_unit

---
 rtl/argmax_unit.sv | 132 +++++++++++++
 tb/tb_argmax_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_unit.sv
// argmax_unit: finds the winning class in a score vector from the fc layer.
// A rising edge of fc_done snapshots the whole score vector, which is then
// scanned one score per cycle while tracking the best and second-best
// scores. The result is held on o_valid/class_idx/max_score/margin until
// the consumer takes it.
//
// Handshake: the result is offered while o_valid is high and is consumed
// on a rising clock edge where o_valid and o_ready are both high. Once
// raised, o_valid stays high and the result stays stable until it is
// consumed. o_ready has no effect while o_valid is low.
module argmax_unit #(
  parameter int CLASSIFICATIONS     = 10,
  parameter int ENDING_ELEMENT_SIZE = 30,
  parameter int IDX_WIDTH           = 4,
  parameter int SIGNED              = 0
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         fc_done,
  input  logic [CLASSIFICATIONS*ENDING_ELEMENT_SIZE-1:0] fc_featuremap,
  input  logic                                         o_ready,
  output logic                                         o_valid,
  output logic [IDX_WIDTH-1:0]                         class_idx,
  output logic [ENDING_ELEMENT_SIZE-1:0]               max_score,
  output logic [ENDING_ELEMENT_SIZE-1:0]               margin,
  output logic                                         busy,
  output logic                                         overrun,
  output logic [1:0]                                   state_dbg
);

  localparam int E  = ENDING_ELEMENT_SIZE;
  localparam int C  = CLASSIFICATIONS;
  // One extra bit so the counter can reach C, which marks the result cycle.
  localparam int CW = IDX_WIDTH + 1;
  localparam logic [CW-1:0] CNT_END = CW'(C);
  // Smallest representable score: the neutral starting value for second-best.
  localparam logic [E-1:0] TYPE_MIN = (SIGNED != 0) ? {1'b1, {(E-1){1'b0}}} : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              state;
  logic                done_q;
  logic [C*E-1:0]      fm_q;
  logic [CW-1:0]       cnt;
  logic [E-1:0]        best;
  logic [E-1:0]        second;
  logic [IDX_WIDTH-1:0] best_idx;
  logic [E-1:0]        score_sel;
  logic                capture;

  // Strictly-greater compare in the configured number representation.
  function automatic logic gt(input logic [E-1:0] a, input logic [E-1:0] b);
    if (SIGNED != 0) gt = ($signed(a) > $signed(b));
    else             gt = (a > b);
  endfunction

  assign capture   = fc_done & ~done_q;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Select the score addressed by the scan counter from the snapshot.
  always_comb begin
    score_sel = '0;
    for (int i = 0; i < C; i++) begin
      if (cnt == CW'(i)) score_sel = fm_q[i*E +: E];
    end
  end

  // Control FSM, scan datapath and registered result outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      done_q    <= 1'b1;
      fm_q      <= '0;
      cnt       <= '0;
      best      <= '0;
      second    <= '0;
      best_idx  <= '0;
      o_valid   <= 1'b0;
      class_idx <= '0;
      max_score <= '0;
      margin    <= '0;
      overrun   <= 1'b0;
    end else begin
      done_q <= fc_done;
      if (capture && (state != IDLE)) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (capture) begin
            fm_q     <= fc_featuremap;
            best     <= fc_featuremap[E-1:0];
            best_idx <= '0;
            second   <= TYPE_MIN;
            cnt      <= CW'(1);
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (cnt == CNT_END) begin
            // All scores seen: publish the result.
            class_idx <= best_idx;
            max_score <= best;
            margin    <= best - second;
            o_valid   <= 1'b1;
            state     <= HOLD;
          end else begin
            if (gt(score_sel, best)) begin
              second   <= best;
              best     <= score_sel;
              best_idx <= cnt[IDX_WIDTH-1:0];
            end else if (gt(score_sel, second)) begin
              second <= score_sel;
            end
            cnt <= cnt + CW'(1);
          end
        end
        HOLD: begin
          if (o_ready) begin
            o_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_unit.sv
// Bench for argmax_unit: an unsigned and a signed instance share stimulus;
// a behavioural model predicts every output each cycle, plus literal
// checks for the hand-worked vectors.
module tb_argmax_unit;

  localparam int C  = 10;
  localparam int E  = 30;
  localparam int IW = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           fc_done = 1'b0;
  logic           o_ready = 1'b0;
  logic [C*E-1:0] fm = '0;

  logic           o_valid_d [2];
  logic [IW-1:0]  idx_d     [2];
  logic [E-1:0]   max_d     [2];
  logic [E-1:0]   mrg_d     [2];
  logic           busy_d    [2];
  logic           ovr_d     [2];
  logic [1:0]     st_d      [2];

  int checks = 0;
  int errors = 0;

  logic [E-1:0] sc [C];

  // model state
  bit            m_done_q = 1'b1;
  bit            m_cap    = 1'b0;
  int            m_wait   = 0;
  bit            m_hold   = 1'b0;
  bit            m_ovr    = 1'b0;
  logic [IW-1:0] m_idx [2] = '{default: '0};
  logic [E-1:0]  m_max [2] = '{default: '0};
  logic [E-1:0]  m_mrg [2] = '{default: '0};
  logic [IW-1:0] p_idx [2] = '{default: '0};
  logic [E-1:0]  p_max [2] = '{default: '0};
  logic [E-1:0]  p_mrg [2] = '{default: '0};

  always #5 clk = ~clk;

  argmax_unit #(.CLASSIFICATIONS(C), .ENDING_ELEMENT_SIZE(E), .IDX_WIDTH(IW), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .fc_done(fc_done), .fc_featuremap(fm), .o_ready(o_ready),
    .o_valid(o_valid_d[0]), .class_idx(idx_d[0]), .max_score(max_d[0]), .margin(mrg_d[0]),
    .busy(busy_d[0]), .overrun(ovr_d[0]), .state_dbg(st_d[0])
  );

  argmax_unit #(.CLASSIFICATIONS(C), .ENDING_ELEMENT_SIZE(E), .IDX_WIDTH(IW), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .fc_done(fc_done), .fc_featuremap(fm), .o_ready(o_ready),
    .o_valid(o_valid_d[1]), .class_idx(idx_d[1]), .max_score(max_d[1]), .margin(mrg_d[1]),
    .busy(busy_d[1]), .overrun(ovr_d[1]), .state_dbg(st_d[1])
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit gt(input logic [E-1:0] a, input logic [E-1:0] b, input int sgn);
    if (sgn != 0) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  // Winner = first maximum; runner-up = largest of all the other entries.
  task automatic compute(input logic [C*E-1:0] v);
    for (int k = 0; k < 2; k++) begin
      int bi;
      logic [E-1:0] sec;
      bi = 0;
      for (int i = 1; i < C; i++)
        if (gt(v[i*E +: E], v[bi*E +: E], k)) bi = i;
      sec = (k != 0) ? {1'b1, {(E-1){1'b0}}} : '0;
      for (int j = 0; j < C; j++)
        if (j != bi && gt(v[j*E +: E], sec, k)) sec = v[j*E +: E];
      p_idx[k] = IW'(bi);
      p_max[k] = v[bi*E +: E];
      p_mrg[k] = v[bi*E +: E] - sec;
    end
  endtask

  // Behavioural model: a capture produces its result C edges later.
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_done_q = 1'b1; m_wait = 0; m_hold = 1'b0; m_ovr = 1'b0;
      for (int k = 0; k < 2; k++) begin m_idx[k] = '0; m_max[k] = '0; m_mrg[k] = '0; end
    end else begin
      m_cap    = fc_done && !m_done_q;
      m_done_q = fc_done;
      if (m_hold) begin
        if (m_cap) m_ovr = 1'b1;
        if (o_ready) m_hold = 1'b0;
      end else if (m_wait > 0) begin
        if (m_cap) m_ovr = 1'b1;
        m_wait--;
        if (m_wait == 0) begin
          m_hold = 1'b1;
          for (int k = 0; k < 2; k++) begin m_idx[k] = p_idx[k]; m_max[k] = p_max[k]; m_mrg[k] = p_mrg[k]; end
        end
      end else if (m_cap) begin
        compute(fm);
        m_wait = C;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d_o_valid", k), 64'(o_valid_d[k]), 64'(m_hold));
      chk($sformatf("d%0d_busy", k), 64'(busy_d[k]), 64'((m_wait > 0) || m_hold));
      chk($sformatf("d%0d_overrun", k), 64'(ovr_d[k]), 64'(m_ovr));
      chk($sformatf("d%0d_class_idx", k), 64'(idx_d[k]), 64'(m_idx[k]));
      chk($sformatf("d%0d_max_score", k), 64'(max_d[k]), 64'(m_max[k]));
      chk($sformatf("d%0d_margin", k), 64'(mrg_d[k]), 64'(m_mrg[k]));
    end
  end

  function automatic logic [C*E-1:0] build();
    logic [C*E-1:0] v;
    for (int i = 0; i < C; i++) v[i*E +: E] = sc[i];
    return v;
  endfunction

  // Raise fc_done with the current scores, scramble the live bus after the
  // capture edge and measure the edges until o_valid.
  task automatic run_vec(input string nm);
    int lat;
    bit found;
    @(negedge clk);
    fm = build();
    fc_done = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < C; i++) fm[i*E +: E] = E'($urandom);
    lat = 0; found = 1'b0;
    for (int n = 1; n <= 20 && !found; n++) begin
      @(posedge clk);
      #1;
      if (o_valid_d[0]) begin found = 1'b1; lat = n; end
    end
    chk({nm, "_latency"}, 64'(lat), 64'(C));
  endtask

  task automatic release_res(input string nm);
    @(negedge clk);
    o_ready = 1'b1;
    fc_done = 1'b0;
    @(posedge clk);
    #1;
    chk({nm, "_valid_drop"}, 64'(o_valid_d[0]), 64'd0);
    @(negedge clk);
    o_ready = 1'b0;
  endtask

  task automatic set_ramp();
    for (int i = 0; i < C; i++) sc[i] = E'(7 * i);
  endtask

  task automatic set_tie();
    for (int i = 0; i < C; i++) sc[i] = E'(100);
    sc[3] = E'(500);
    sc[7] = E'(500);
  endtask

  initial begin
    int pulses;
    // reset
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(o_valid_d[0]), 64'd0);
    chk("rst_busy", 64'(busy_d[0]), 64'd0);
    chk("rst_max", 64'(max_d[0]), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // unsigned ramp
    set_ramp();
    run_vec("ramp");
    chk("ramp_idx", 64'(idx_d[0]), 64'd9);
    chk("ramp_max", 64'(max_d[0]), 64'd63);
    chk("ramp_margin", 64'(mrg_d[0]), 64'd7);
    chk("ramp_model_idx", 64'(m_idx[0]), 64'd9);
    chk("ramp_model_margin", 64'(m_mrg[0]), 64'd7);
    release_res("ramp");
    repeat (2) @(negedge clk);

    // tie: lowest index wins, margin zero
    set_tie();
    run_vec("tie");
    chk("tie_idx", 64'(idx_d[0]), 64'd3);
    chk("tie_max", 64'(max_d[0]), 64'd500);
    chk("tie_margin", 64'(mrg_d[0]), 64'd0);
    chk("tie_model_idx", 64'(m_idx[0]), 64'd3);
    release_res("tie");
    repeat (2) @(negedge clk);

    // signed vector
    for (int i = 0; i < C; i++) sc[i] = -30'sd10;
    sc[2] = -30'sd4;
    sc[6] = -30'sd3;
    run_vec("sgn");
    chk("sgn_idx", 64'(idx_d[1]), 64'd6);
    chk("sgn_max", 64'(max_d[1]), 64'h3FFFFFFD);
    chk("sgn_margin", 64'(mrg_d[1]), 64'd1);
    chk("sgn_model_max", 64'(m_max[1]), 64'h3FFFFFFD);
    release_res("sgn");
    repeat (2) @(negedge clk);

    // backpressure with an fc_done pulse during HOLD
    set_ramp();
    run_vec("bp");
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (cyc == 3) fc_done = 1'b0;
      if (cyc == 5) begin
        fc_done = 1'b1;
        for (int i = 0; i < C; i++) fm[i*E +: E] = E'($urandom);
      end
    end
    chk("bp_overrun", 64'(ovr_d[0]), 64'd1);
    chk("bp_valid", 64'(o_valid_d[0]), 64'd1);
    chk("bp_idx", 64'(idx_d[0]), 64'd9);
    chk("bp_max", 64'(max_d[0]), 64'd63);
    release_res("bp");
    @(negedge clk);
    chk("bp_overrun_sticky", 64'(ovr_d[0]), 64'd1);
    chk("bp_idle", 64'(busy_d[0]), 64'd0);

    // reset in the 4th SCAN cycle, fc_done held across release
    set_tie();
    @(negedge clk);
    fm = build();
    fc_done = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy_d[0]), 64'd0);
    chk("mid_rst_valid", 64'(o_valid_d[0]), 64'd0);
    chk("mid_rst_overrun", 64'(ovr_d[0]), 64'd0);
    chk("mid_rst_idx", 64'(idx_d[0]), 64'd0);
    chk("mid_rst_max", 64'(max_d[0]), 64'd0);
    chk("mid_rst_margin", 64'(mrg_d[0]), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    chk("post_rst_busy", 64'(busy_d[0]), 64'd0);
    chk("post_rst_valid", 64'(o_valid_d[0]), 64'd0);
    fc_done = 1'b0;
    run_vec("rerun");
    chk("rerun_idx", 64'(idx_d[0]), 64'd3);
    chk("rerun_max", 64'(max_d[0]), 64'd500);
    release_res("rerun");
    repeat (2) @(negedge clk);

    // fc_done held high 50 cycles with o_ready tied high
    set_ramp();
    @(negedge clk);
    fm = build();
    o_ready = 1'b1;
    fc_done = 1'b1;
    pulses = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      if (o_valid_d[0]) pulses++;
    end
    chk("held_pulses", 64'(pulses), 64'd1);
    chk("held_overrun", 64'(ovr_d[0]), 64'd0);
    fc_done = 1'b0;
    o_ready = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
